// File: rtl/coproc_pkg.sv
// coproc_pkg
//   Shared definitions for the coprocessor fetch sequencer:
//   - state_t        : sequencer FSM state encoding
//   - header_t       : decoded job header word
//   - decode_header  : extracts op / size / count from a 16-bit header word
//   - DEFAULT_TIMEOUT: default coprocessor wait budget in cycles
package coproc_pkg;

   localparam int DEFAULT_TIMEOUT = 255;

   // Header word layout: op in [2:0], size in [4:3], bits [7:5] unused,
   // operation count in [15:8].
   localparam int HDR_OP_LSB    = 0;
   localparam int HDR_OP_W      = 3;
   localparam int HDR_SIZE_LSB  = 3;
   localparam int HDR_SIZE_W    = 2;
   localparam int HDR_COUNT_LSB = 8;
   localparam int HDR_COUNT_W   = 8;

   typedef enum logic [3:0] {
      IDLE,
      HDR_RD,
      HDR_WAIT,
      OP_RD,
      OP_WAIT,
      CP_GO,
      CP_WAIT,
      WR,
      FIN
   } state_t;

   typedef struct packed {
      logic [HDR_COUNT_W-1:0] count;
      logic [HDR_SIZE_W-1:0]  size;
      logic [HDR_OP_W-1:0]    op;
   } header_t;

   function automatic header_t decode_header(input logic [15:0] word);
      header_t h;
      h.op    = word[HDR_OP_LSB    +: HDR_OP_W];
      h.size  = word[HDR_SIZE_LSB  +: HDR_SIZE_W];
      h.count = word[HDR_COUNT_LSB +: HDR_COUNT_W];
      return h;
   endfunction

endpackage

// File: rtl/timeout_counter.sv
// timeout_counter
//   Down-counter that bounds how long the sequencer waits for the coprocessor.
//   Ports:
//     clk     - clock
//     rst     - synchronous active-high reset
//     load    - preload the counter for a fresh wait window
//     enable  - high during every cycle of the wait window
//     expired - high in the last cycle of a TIMEOUT-cycle window (while enabled)
//   TIMEOUT must be at least 1.
module timeout_counter
   import coproc_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT - 1);

   logic [CW-1:0] cnt;

   // The first enabled cycle sees TIMEOUT-1, so zero is reached exactly in
   // the TIMEOUT-th enabled cycle; the counter saturates at zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= LOAD_VAL;
      end else if (enable && (cnt != '0)) begin
         cnt <= cnt - CW'(1);
      end
   end

   assign expired = enable && (cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Reads a job header and a list of operand words from memory, runs each
//   operand pair through the coprocessor and writes every result back.
//   Memory layout for a job at base:
//     base            header  (op [2:0], size [4:3], count [15:8])
//     base+1+i        operand i (operand1 [7:0], operand2 [15:8])
//     base+1+count+i  result i
//   All addresses wrap modulo 2^ADDR_W.
//   Ports:
//     clk, rst                  - clock, synchronous active-high reset
//     start, base_addr          - job launch pulse and header address
//     busy, done, err           - job status (err = coprocessor timeout)
//     mem_addr, mem_wren,
//     mem_data, mem_q           - synchronous memory (read data one cycle later)
//     cp_start, cp_op, cp_size,
//     cp_operand1, cp_operand2  - coprocessor request
//     cp_result, cp_ready       - coprocessor response
module fetch_sequencer
   import coproc_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_wren,
   output logic [15:0]       mem_data,
   input  logic [15:0]       mem_q,
   output logic              cp_start,
   output logic [2:0]        cp_op,
   output logic [1:0]        cp_size,
   output logic [7:0]        cp_operand1,
   output logic [7:0]        cp_operand2,
   input  logic [15:0]       cp_result,
   input  logic              cp_ready
);

   state_t            state;
   logic [ADDR_W-1:0] base;
   logic [7:0]        count;
   logic [7:0]        idx;
   header_t           hdr;
   logic [ADDR_W-1:0] next_rd_addr;
   logic [ADDR_W-1:0] wr_addr;
   logic              tmo_load;
   logic              tmo_enable;
   logic              tmo_expired;

   assign hdr = decode_header(mem_q);

   // Operand idx+1 lives at base+2+idx; result idx at base+1+count+idx.
   assign next_rd_addr = base + ADDR_W'(idx) + ADDR_W'(2);
   assign wr_addr      = base + ADDR_W'(count) + ADDR_W'(idx) + ADDR_W'(1);

   // The wait window is armed during CP_GO so that CP_WAIT can last at most
   // TIMEOUT cycles.
   assign tmo_load   = (state == CP_GO);
   assign tmo_enable = (state == CP_WAIT);

   timeout_counter #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (tmo_load),
      .enable (tmo_enable),
      .expired(tmo_expired)
   );

   // Sequencer FSM. All outputs are registered and are set on the edge that
   // enters the state they belong to, so e.g. mem_wren is high exactly in WR
   // and cp_start exactly in CP_GO. cp_ready wins over an expiring timeout.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         mem_addr    <= '0;
         mem_wren    <= 1'b0;
         mem_data    <= '0;
         cp_start    <= 1'b0;
         cp_op       <= '0;
         cp_size     <= '0;
         cp_operand1 <= '0;
         cp_operand2 <= '0;
         base        <= '0;
         count       <= '0;
         idx         <= '0;
      end else begin
         done     <= 1'b0;
         mem_wren <= 1'b0;
         cp_start <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= HDR_RD;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  base     <= base_addr;
                  mem_addr <= base_addr;
               end
            end
            HDR_RD: begin
               state <= HDR_WAIT;
            end
            HDR_WAIT: begin
               cp_op   <= hdr.op;
               cp_size <= hdr.size;
               count   <= hdr.count;
               idx     <= '0;
               if (hdr.count == 8'd0) begin
                  state <= FIN;
                  done  <= 1'b1;
               end else begin
                  state    <= OP_RD;
                  mem_addr <= base + ADDR_W'(1);
               end
            end
            OP_RD: begin
               state <= OP_WAIT;
            end
            OP_WAIT: begin
               cp_operand1 <= mem_q[7:0];
               cp_operand2 <= mem_q[15:8];
               cp_start    <= 1'b1;
               state       <= CP_GO;
            end
            CP_GO: begin
               state <= CP_WAIT;
            end
            CP_WAIT: begin
               if (cp_ready) begin
                  mem_data <= cp_result;
                  mem_addr <= wr_addr;
                  mem_wren <= 1'b1;
                  state    <= WR;
               end else if (tmo_expired) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= FIN;
               end
            end
            WR: begin
               if (idx == count - 8'd1) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  idx      <= idx + 8'd1;
                  mem_addr <= next_rd_addr;
                  state    <= OP_RD;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer
//   Self-checking bench for fetch_sequencer (TIMEOUT=8, ADDR_W=8).
//   A responder process models the synchronous memory and the coprocessor;
//   expected operand requests and memory writes are queued when a job is
//   launched and compared as the DUT produces them.
module tb_fetch_sequencer;

   localparam int TIMEOUT = 8;
   localparam int ADDR_W  = 8;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  mem_addr;
   logic        mem_wren;
   logic [15:0] mem_data;
   logic [15:0] mem_q;
   logic        cp_start;
   logic [2:0]  cp_op;
   logic [1:0]  cp_size;
   logic [7:0]  cp_operand1;
   logic [7:0]  cp_operand2;
   logic [15:0] cp_result;
   logic        cp_ready;

   fetch_sequencer #(
      .TIMEOUT(TIMEOUT),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .mem_addr   (mem_addr),
      .mem_wren   (mem_wren),
      .mem_data   (mem_data),
      .mem_q      (mem_q),
      .cp_start   (cp_start),
      .cp_op      (cp_op),
      .cp_size    (cp_size),
      .cp_operand1(cp_operand1),
      .cp_operand2(cp_operand2),
      .cp_result  (cp_result),
      .cp_ready   (cp_ready)
   );

   // delay = CP_WAIT cycle (1-based) in which cp_ready rises, 0 = never.
   // poke  = cycle after start in which a stray start pulse is driven, 0 = none.
   typedef struct packed {
      logic [7:0]       base;
      logic [15:0]      hdr;
      logic [3:0][15:0] opw;
      logic [3:0][15:0] res;
      logic [7:0]       delay;
      logic [7:0]       poke;
      logic             exp_err;
   } job_t;

   typedef struct packed {
      logic [7:0]  addr;
      logic [15:0] data;
   } wr_t;

   typedef struct packed {
      logic [2:0] op;
      logic [1:0] size;
      logic [7:0] o1;
      logic [7:0] o2;
   } op_t;

   wr_t         exp_wr[$];
   op_t         exp_op[$];
   logic [15:0] cp_res_q[$];
   logic [15:0] mem [0:255];

   int passed;
   int total;
   int wren_cnt;
   int cp_start_cnt;
   int done_cnt;
   int cp_delay;
   logic [7:0] held_o1;
   logic [7:0] held_o2;

   job_t jobs[6];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual === expected) begin
         passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_busy"},     32'(busy),        32'd0);
      checkOutput({tag, "_done"},     32'(done),        32'd0);
      checkOutput({tag, "_err"},      32'(err),         32'd0);
      checkOutput({tag, "_mem_wren"}, 32'(mem_wren),    32'd0);
      checkOutput({tag, "_cp_start"}, 32'(cp_start),    32'd0);
      checkOutput({tag, "_mem_addr"}, 32'(mem_addr),    32'd0);
      checkOutput({tag, "_mem_data"}, 32'(mem_data),    32'd0);
      checkOutput({tag, "_cp_op"},    32'(cp_op),       32'd0);
      checkOutput({tag, "_cp_size"},  32'(cp_size),     32'd0);
      checkOutput({tag, "_operand1"}, 32'(cp_operand1), 32'd0);
      checkOutput({tag, "_operand2"}, 32'(cp_operand2), 32'd0);
   endtask

   function automatic job_t mkJob(input logic [7:0] base, input logic [15:0] hdr,
                                  input logic [63:0] opw, input logic [63:0] res,
                                  input logic [7:0] delay, input logic [7:0] poke,
                                  input logic exp_err);
      job_t j;
      j.base    = base;
      j.hdr     = hdr;
      j.opw     = opw;
      j.res     = res;
      j.delay   = delay;
      j.poke    = poke;
      j.exp_err = exp_err;
      return j;
   endfunction

   // Memory and coprocessor responder plus output monitor. DUT outputs are
   // sampled mid-cycle; responses are driven 1 time unit after the edge.
   initial begin : responder
      logic [7:0]  s_addr;
      logic        s_wren;
      logic [15:0] s_data;
      logic        s_start;
      logic        s_rst;
      logic        armed;
      int          wt;
      wr_t         w;
      op_t         e;
      armed     = 1'b0;
      wt        = 0;
      mem_q     = '0;
      cp_ready  = 1'b0;
      cp_result = '0;
      forever begin
         @(negedge clk);
         s_addr  = mem_addr;
         s_wren  = mem_wren;
         s_data  = mem_data;
         s_start = cp_start;
         s_rst   = rst;
         if (done) done_cnt++;
         if (s_wren) begin
            wren_cnt++;
            if (exp_wr.size() > 0) begin
               w = exp_wr.pop_front();
               checkOutput("wr_addr", 32'(s_addr), 32'(w.addr));
               checkOutput("wr_data", 32'(s_data), 32'(w.data));
            end
            mem[s_addr] = s_data;
         end
         if (s_start) begin
            cp_start_cnt++;
            held_o1 = cp_operand1;
            held_o2 = cp_operand2;
            if (exp_op.size() > 0) begin
               e = exp_op.pop_front();
               checkOutput("cp_op",       32'(cp_op),       32'(e.op));
               checkOutput("cp_size",     32'(cp_size),     32'(e.size));
               checkOutput("cp_operand1", 32'(cp_operand1), 32'(e.o1));
               checkOutput("cp_operand2", 32'(cp_operand2), 32'(e.o2));
            end
         end
         if (cp_ready) begin
            checkOutput("hold_operand1", 32'(cp_operand1), 32'(held_o1));
            checkOutput("hold_operand2", 32'(cp_operand2), 32'(held_o2));
         end
         @(posedge clk);
         #1;
         mem_q    = mem[s_addr];
         cp_ready = 1'b0;
         if (s_rst) begin
            armed = 1'b0;
         end else if (s_start && cp_delay > 0) begin
            armed = 1'b1;
            wt    = cp_delay;
         end
         if (armed) begin
            wt--;
            if (wt == 0) begin
               cp_ready  = 1'b1;
               cp_result = (cp_res_q.size() > 0) ? cp_res_q.pop_front() : 16'hDEAD;
               armed     = 1'b0;
            end
         end
      end
   end

   // Loads a job into memory, queues its expectations, launches it and
   // checks status, latency and bookkeeping once it finishes.
   task automatic applyStimulus(input job_t j);
      logic [7:0]  cnt;
      logic [7:0]  a;
      logic [15:0] word;
      op_t         e;
      wr_t         w;
      int          n_ops;
      int          n_wr;
      int          wr0;
      int          cs0;
      int          dn0;
      int          k_done;
      bit          seen;
      cnt = j.hdr[15:8];
      mem[j.base] = j.hdr;
      for (int i = 0; i < int'(cnt); i++) begin
         a      = j.base + 8'd1 + 8'(i);
         mem[a] = j.opw[i];
      end
      n_ops = (cnt == 8'd0) ? 0 : (j.exp_err ? 1 : int'(cnt));
      n_wr  = j.exp_err ? 0 : int'(cnt);
      for (int i = 0; i < n_ops; i++) begin
         word   = j.opw[i];
         e.op   = j.hdr[2:0];
         e.size = j.hdr[4:3];
         e.o1   = word[7:0];
         e.o2   = word[15:8];
         exp_op.push_back(e);
      end
      for (int i = 0; i < n_wr; i++) begin
         w.addr = j.base + 8'd1 + cnt + 8'(i);
         w.data = j.res[i];
         exp_wr.push_back(w);
         cp_res_q.push_back(j.res[i]);
      end
      cp_delay = int'(j.delay);
      wr0 = wren_cnt;
      cs0 = cp_start_cnt;
      dn0 = done_cnt;

      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = j.base;
      seen      = 1'b0;
      k_done    = 0;
      for (int k = 1; k <= 300 && !seen; k++) begin
         @(posedge clk);
         #1;
         start     = (k == int'(j.poke));
         base_addr = (k == int'(j.poke)) ? 8'h99 : j.base;
         @(negedge clk);
         if (k == 1) begin
            checkOutput("busy_on", 32'(busy), 32'd1);
            checkOutput("err_clr", 32'(err),  32'd0);
         end
         if (done) begin
            seen   = 1'b1;
            k_done = k;
            checkOutput("err_with_done", 32'(err), 32'(j.exp_err));
         end
      end
      checkOutput("done_seen", 32'(seen), 32'd1);
      if (cnt == 8'd0) checkOutput("latency_count0", 32'(k_done), 32'd3);

      @(posedge clk);
      #1;
      start     = 1'b0;
      base_addr = '0;
      @(negedge clk);
      checkOutput("busy_off", 32'(busy), 32'd0);
      checkOutput("done_pulse", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      checkOutput("err_hold",      32'(err),                  32'(j.exp_err));
      checkOutput("done_count",    32'(done_cnt - dn0),       32'd1);
      checkOutput("write_count",   32'(wren_cnt - wr0),       32'(n_wr));
      checkOutput("cp_start_count",32'(cp_start_cnt - cs0),   32'(n_ops));
      checkOutput("writes_left",   32'(exp_wr.size()),        32'd0);
      checkOutput("ops_left",      32'(exp_op.size()),        32'd0);
      exp_wr.delete();
      exp_op.delete();
      cp_res_q.delete();
   endtask

   initial begin : main
      int cs0;
      int wr0;
      int dn0;
      int guard;
      op_t e;
      passed       = 0;
      total        = 0;
      wren_cnt     = 0;
      cp_start_cnt = 0;
      done_cnt     = 0;
      cp_delay     = 0;
      held_o1      = '0;
      held_o2      = '0;
      rst          = 1'b1;
      start        = 1'b0;
      base_addr    = '0;
      for (int a = 0; a < 256; a++) mem[a] = 16'h0000;

      //                base    hdr       operands                 results                  dly   poke  err
      jobs[0] = mkJob(8'h10, 16'h0203, 64'h0000_0000_0403_0201, 64'h0000_0000_BBBB_AAAA, 8'd4, 8'd6, 1'b0);
      jobs[1] = mkJob(8'h20, 16'h00E5, 64'h0,                   64'h0,                   8'd1, 8'd3, 1'b0);
      jobs[2] = mkJob(8'hFE, 16'h021D, 64'h0000_0000_3344_1122, 64'h0000_0000_5678_1234, 8'd1, 8'd0, 1'b0);
      jobs[3] = mkJob(8'h40, 16'h03F2, 64'h0000_3333_2222_1111, 64'h0000_C003_C002_C001, 8'd8, 8'd0, 1'b0);
      jobs[4] = mkJob(8'h50, 16'h0201, 64'h0000_0000_0C0D_0A0B, 64'h0,                   8'd0, 8'd0, 1'b1);
      jobs[5] = mkJob(8'h60, 16'h010E, 64'h0000_0000_0000_7788, 64'h0,                   8'd9, 8'd0, 1'b1);

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int t = 0; t < 6; t++) begin
         $display("[TB] job %0d base 0x%02h header 0x%04h", t, jobs[t].base, jobs[t].hdr);
         applyStimulus(jobs[t]);
      end

      // Reset while waiting on the coprocessor: nothing may follow it.
      $display("[TB] reset during CP_WAIT");
      mem[8'h70] = 16'h0207;
      mem[8'h71] = 16'h0605;
      mem[8'h72] = 16'h0807;
      e.op   = 3'd7;
      e.size = 2'd0;
      e.o1   = 8'h05;
      e.o2   = 8'h06;
      exp_op.push_back(e);
      cp_delay = 0;
      cs0 = cp_start_cnt;
      wr0 = wren_cnt;
      dn0 = done_cnt;
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = 8'h70;
      @(posedge clk);
      #1;
      start = 1'b0;
      guard = 0;
      while (cp_start_cnt == cs0 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("abort_cp_start_seen", 32'(cp_start_cnt - cs0), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkResetOutputs("abort");
      repeat (15) @(negedge clk);
      checkOutput("abort_no_write",    32'(wren_cnt - wr0),     32'd0);
      checkOutput("abort_no_cp_start", 32'(cp_start_cnt - cs0), 32'd1);
      checkOutput("abort_no_done",     32'(done_cnt - dn0),     32'd0);
      exp_op.delete();

      $display("[TB] clean job after reset");
      applyStimulus(jobs[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
